// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : opcodes, funct3 size codes, FSM states, fault check
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] c_OP_STORE = 7'b0100011;

   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_t;

   // Unsigned sizes exist only for loads; a store with them is illegal.
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
      logic fault;
      case (f3)
         c_F3_B:  fault = 1'b0;
         c_F3_H:  fault = a[0];
         c_F3_W:  fault = (a != 2'b00);
         c_F3_BU: fault = is_store;
         c_F3_HU: fault = is_store | a[0];
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
// lsu_load_align : selects the addressed byte/half of a read word and extends it
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      o_load_value = i_rdata;
      case (i_funct3)
         c_F3_B:  o_load_value = {{24{w_byte[7]}}, w_byte};
         c_F3_H:  o_load_value = {{16{w_half[15]}}, w_half};
         c_F3_BU: o_load_value = {24'h000000, w_byte};
         c_F3_HU: o_load_value = {16'h0000, w_half};
         default: o_load_value = i_rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : LOAD/STORE sequencer for a word-addressed valid/ready memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_wstrb,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_load_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   lsu_state_t      r_state;
   logic            r_is_store;
   logic [2:0]      r_funct3;
   logic [1:0]      r_addr_lo;
   logic [CW-1:0]   r_cnt;

   logic            w_is_load;
   logic            w_is_store;
   logic            w_fault;
   logic [3:0]      w_wstrb;
   logic [31:0]     w_wdata;
   logic [31:0]     w_load_value;

   assign w_is_load  = (i_opcode == c_OP_LOAD);
   assign w_is_store = (i_opcode == c_OP_STORE);
   assign w_fault    = access_fault(w_is_store, i_funct3, i_addr[1:0]);
   assign o_busy     = (r_state != S_IDLE);

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = i_store_data;
      case (i_funct3)
         c_F3_B: begin
            w_wstrb = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_store_data[7:0]}};
         end
         c_F3_H: begin
            w_wstrb = 4'b0011 << {i_addr[1], 1'b0};
            w_wdata = {2{i_store_data[15:0]}};
         end
         c_F3_W:  w_wstrb = 4'b1111;
         default: w_wstrb = 4'b0000;
      endcase
   end

   lsu_load_align u_load_align (
      .i_rdata      (i_mem_rdata),
      .i_addr_lo    (r_addr_lo),
      .i_funct3     (r_funct3),
      .o_load_value (w_load_value)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_is_store  <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_cnt       <= '0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= 32'h0;
         o_mem_wstrb <= 4'h0;
         o_mem_wdata <= 32'h0;
         o_load_data <= 32'h0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start && (w_is_load || w_is_store)) begin
                  r_is_store <= w_is_store;
                  r_funct3   <= i_funct3;
                  r_addr_lo  <= i_addr[1:0];
                  r_cnt      <= '0;
                  o_mem_we   <= w_is_store;
                  o_mem_addr <= {i_addr[31:2], 2'b00};
                  o_mem_wdata <= w_wdata;
                  o_err      <= 1'b0;
                  if (w_fault) begin
                     // Faulting requests never reach memory.
                     o_mem_wstrb <= 4'h0;
                     o_done      <= 1'b1;
                     o_err       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     o_mem_wstrb <= w_is_store ? w_wstrb : 4'h0;
                     o_mem_req   <= 1'b1;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_ready) begin
                  o_mem_req <= 1'b0;
                  o_done    <= 1'b1;
                  r_state   <= S_DONE;
                  if (!r_is_store) begin
                     o_load_data <= w_load_value;
                  end
               end else if ((TIMEOUT_CYC != 0) && (32'(r_cnt) == TIMEOUT_CYC - 1)) begin
                  o_mem_req <= 1'b0;
                  o_done    <= 1'b1;
                  o_err     <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [6:0]  i_opcode = 7'h0;
   logic [2:0]  i_funct3 = 3'h0;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_store_data = 32'h0;
   logic        i_mem_ready = 1'b0;
   logic [31:0] i_mem_rdata = 32'h0;
   logic        o_mem_req, o_mem_we, o_busy, o_done, o_err;
   logic [31:0] o_mem_addr, o_mem_wdata, o_load_data;
   logic [3:0]  o_mem_wstrb;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_opcode(i_opcode),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
      .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
      .o_load_data(o_load_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; returns 1ns after the acceptance edge.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      i_start = 1'b1; i_opcode = op; i_funct3 = f3; i_addr = a; i_store_data = sd;
      tick();
      i_start = 1'b0;
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
      issue(OP_LOAD, f3, a, 32'h0);
      checks++;
      if (o_mem_req !== 1'b1) begin
         errors++; $display("FAIL load_req f3=%0d: got %b want 1", f3, o_mem_req);
      end
      i_mem_ready = 1'b1; i_mem_rdata = rdata;
      tick();
      i_mem_ready = 1'b0;
      checks++;
      if (o_done !== 1'b1 || o_load_data !== exp || o_err !== 1'b0) begin
         errors++;
         $display("FAIL load_data f3=%0d addr=%h: got done=%b err=%b data=%h want done=1 err=0 data=%h",
                  f3, a, o_done, o_err, o_load_data, exp);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({o_mem_req, o_mem_we, o_done, o_err, o_busy} !== 5'b0 || o_mem_wstrb !== 4'h0 ||
          o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_load_data !== 32'h0) begin
         errors++;
         $display("FAIL reset: got req=%b we=%b done=%b err=%b busy=%b wstrb=%h addr=%h wdata=%h ld=%h want all 0",
                  o_mem_req, o_mem_we, o_done, o_err, o_busy, o_mem_wstrb, o_mem_addr, o_mem_wdata, o_load_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lw();
      issue(OP_LOAD, 3'b010, 32'h100, 32'h0);
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h100 ||
          o_mem_wstrb !== 4'h0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL lw_req: got req=%b we=%b addr=%h wstrb=%h busy=%b want 1 0 00000100 0 1",
                  o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_busy);
      end
      tick();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL lw_wait: got req=%b addr=%h done=%b want 1 00000100 0", o_mem_req, o_mem_addr, o_done);
      end
      i_mem_ready = 1'b1; i_mem_rdata = 32'hDEADBEEF;
      tick();
      i_mem_ready = 1'b0;
      checks++;
      if (o_done !== 1'b1 || o_load_data !== 32'hDEADBEEF || o_err !== 1'b0 ||
          o_mem_req !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL lw_done: got done=%b data=%h err=%b req=%b busy=%b want 1 deadbeef 0 0 1",
                  o_done, o_load_data, o_err, o_mem_req, o_busy);
      end
      // Start presented during DONE must be ignored.
      i_start = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_addr = 32'h600;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL lw_idle: got done=%b busy=%b req=%b want 0 0 0", o_done, o_busy, o_mem_req);
      end
   endtask

   task automatic test_load_formats();
      run_load(3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80);
      run_load(3'b100, 32'h103, 32'h80123456, 32'h00000080);
      run_load(3'b001, 32'h102, 32'h80123456, 32'hFFFF8012);
      run_load(3'b101, 32'h100, 32'h80123456, 32'h00003456);
      run_load(3'b000, 32'h101, 32'h80123456, 32'h00000034);
   endtask

   task automatic test_store();
      logic [31:0] keep;
      keep = o_load_data;
      issue(OP_STORE, 3'b000, 32'h201, 32'h000000AB);
      checks++;
      if (o_mem_we !== 1'b1 || o_mem_wstrb !== 4'b0010 || o_mem_wdata !== 32'hABABABAB ||
          o_mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL sb: got we=%b wstrb=%b wdata=%h addr=%h want 1 0010 abababab 00000200",
                  o_mem_we, o_mem_wstrb, o_mem_wdata, o_mem_addr);
      end
      i_mem_ready = 1'b1; tick(); i_mem_ready = 1'b0;
      checks++;
      if (o_done !== 1'b1 || o_load_data !== keep || o_err !== 1'b0) begin
         errors++;
         $display("FAIL sb_done: got done=%b ld=%h err=%b want 1 %h 0", o_done, o_load_data, o_err, keep);
      end
      tick();
      issue(OP_STORE, 3'b001, 32'h202, 32'h00001234);
      checks++;
      if (o_mem_wstrb !== 4'b1100 || o_mem_wdata !== 32'h12341234 || o_mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL sh: got wstrb=%b wdata=%h addr=%h want 1100 12341234 00000200",
                  o_mem_wstrb, o_mem_wdata, o_mem_addr);
      end
      i_mem_ready = 1'b1; tick(); i_mem_ready = 1'b0; tick();
      issue(OP_STORE, 3'b010, 32'h204, 32'hCAFEF00D);
      checks++;
      if (o_mem_wstrb !== 4'b1111 || o_mem_wdata !== 32'hCAFEF00D || o_mem_addr !== 32'h204) begin
         errors++;
         $display("FAIL sw: got wstrb=%b wdata=%h addr=%h want 1111 cafef00d 00000204",
                  o_mem_wstrb, o_mem_wdata, o_mem_addr);
      end
      i_mem_ready = 1'b1; tick(); i_mem_ready = 1'b0; tick();
   endtask

   task automatic test_misaligned();
      logic [31:0] keep;
      keep = o_load_data;
      issue(OP_LOAD, 3'b010, 32'h102, 32'h0);
      checks++;
      if (o_mem_req !== 1'b0 || o_done !== 1'b1 || o_err !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL lw_misalign: got req=%b done=%b err=%b busy=%b want 0 1 1 1",
                  o_mem_req, o_done, o_err, o_busy);
      end
      tick();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b1 || o_load_data !== keep) begin
         errors++;
         $display("FAIL misalign_hold: got done=%b busy=%b err=%b ld=%h want 0 0 1 %h",
                  o_done, o_busy, o_err, o_load_data, keep);
      end
      issue(OP_ALU, 3'b010, 32'h100, 32'h0);
      checks++;
      if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_err !== 1'b1) begin
         errors++;
         $display("FAIL other_opcode: got busy=%b req=%b err=%b want 0 0 1", o_busy, o_mem_req, o_err);
      end
      issue(OP_LOAD, 3'b011, 32'h100, 32'h0);
      checks++;
      if (o_mem_req !== 1'b0 || o_done !== 1'b1 || o_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_f3: got req=%b done=%b err=%b want 0 1 1", o_mem_req, o_done, o_err);
      end
      tick();
      issue(OP_STORE, 3'b001, 32'h201, 32'h1234);
      checks++;
      if (o_mem_req !== 1'b0 || o_done !== 1'b1 || o_err !== 1'b1) begin
         errors++;
         $display("FAIL sh_misalign: got req=%b done=%b err=%b want 0 1 1", o_mem_req, o_done, o_err);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [31:0] keep;
      int          nreq;
      logic        saw_done;
      keep = o_load_data;
      nreq = 0;
      saw_done = 1'b0;
      issue(OP_LOAD, 3'b010, 32'h300, 32'h0);
      checks++;
      if (o_err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b want 0", o_err);
      end
      for (int i = 0; i < 10; i++) begin
         if (o_mem_req === 1'b1) nreq++;
         if (o_done === 1'b1) begin
            saw_done = 1'b1;
            break;
         end
         i_start = (i == 1);
         i_opcode = OP_STORE; i_funct3 = 3'b010; i_addr = 32'h500;
         tick();
      end
      i_start = 1'b0;
      checks++;
      if (nreq != 4 || saw_done !== 1'b1 || o_err !== 1'b1 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got req_cycles=%0d done=%b err=%b req=%b want 4 1 1 0",
                  nreq, saw_done, o_err, o_mem_req);
      end
      checks++;
      if (o_load_data !== keep || o_mem_addr !== 32'h300) begin
         errors++;
         $display("FAIL timeout_hold: got ld=%h addr=%h want %h 00000300", o_load_data, o_mem_addr, keep);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(OP_LOAD, 3'b010, 32'h400, 32'h0);
      checks++;
      if (o_mem_req !== 1'b1) begin
         errors++; $display("FAIL mid_req: got %b want 1", o_mem_req);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_load_data !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: got req=%b busy=%b ld=%h want 0 0 00000000", o_mem_req, o_busy, o_load_data);
      end
      i_mem_ready = 1'b1; i_mem_rdata = 32'h11111111;
      tick();
      i_mem_ready = 1'b0;
      checks++;
      if (o_load_data !== 32'h0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL late_ready: got ld=%h done=%b busy=%b want 00000000 0 0", o_load_data, o_done, o_busy);
      end
   endtask

   task automatic test_back_to_back();
      run_load(3'b010, 32'h700, 32'h01234567, 32'h01234567);
      run_load(3'b001, 32'h702, 32'h7FFF0000, 32'h00007FFF);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_formats();
      test_store();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
